om_frag_packer: RTL and testbench
=================================

Name: om_frag_packer

Overview:
- Upstream neighbour of the OM unit.
- Accepts single shaded fragments, one per cycle, from the fragment/shader return path.
- Packs them into NUM_LANES-wide OM requests (uuid, mask, pos_x/y, color, depth, face) on the OM request handshake.
- A partial request is flushed when the packing buffer is full, the uuid changes, a fragment is marked last, or an idle timeout expires.

Parameters:
NUM_LANES, `NUM_THREADS, lanes per OM request (power of 2, >=1)
DIM_BITS, `VX_OM_DIM_BITS, pixel coordinate width
DEPTH_BITS, `VX_OM_DEPTH_BITS, depth width
COLOR_BITS, 32, packed RGBA color width
UUID_WIDTH, `UUID_WIDTH, request uuid width
FLUSH_TIMEOUT, 16, idle cycles before a partial buffer is flushed; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
frag_valid  in  1  fragment valid
frag_uuid  in  UUID_WIDTH  fragment uuid
frag_pos_x  in  DIM_BITS  x
frag_pos_y  in  DIM_BITS  y
frag_color  in  COLOR_BITS  color
frag_depth  in  DEPTH_BITS  depth
frag_face  in  1  backface flag
frag_last  in  1  flush after this fragment
frag_ready  out  1  fragment accepted when valid&ready
om_req_valid  out  1  request valid
om_req_uuid  out  UUID_WIDTH  request uuid
om_req_mask  out  NUM_LANES  active lanes
om_req_pos_x  out  NUM_LANES*DIM_BITS  per-lane x
om_req_pos_y  out  NUM_LANES*DIM_BITS  per-lane y
om_req_color  out  NUM_LANES*COLOR_BITS  per-lane color
om_req_depth  out  NUM_LANES*DEPTH_BITS  per-lane depth
om_req_face  out  NUM_LANES  per-lane face
om_req_ready  in  1  OM unit accepts request
busy  out  1  count!=0 or om_req_valid

Behaviour:
- State:
  - pack buffer: lanes, buf_uuid, count 0..NUM_LANES
  - pend_flush flag
  - timer
  - output register: out_valid + payload
- Reset (reset low, async):
  - count=0, pend_flush=0, timer=0, out_valid=0, all output payload=0, busy=0.
  - frag_ready is forced 0 while reset is low.
  - Reset mid-operation drops all buffered and pending fragments; no request is emitted for them.
- mismatch = frag_valid & count>0 & frag_uuid!=buf_uuid.
- emit = count>0 & (count==NUM_LANES | pend_flush | mismatch | (FLUSH_TIMEOUT!=0 & timer==FLUSH_TIMEOUT)).
  - emit uses registered state only, apart from mismatch.
- xfer = emit & (!out_valid | om_req_ready).
  - On xfer, the output register loads:
    - uuid = buf_uuid
    - mask = (1<<count)-1
    - lanes >= count are zeroed
  - After xfer: count=0 and pend_flush=0, unless the same cycle accepts a fragment.
- frag_ready = reset_deasserted & ((count<NUM_LANES & !pend_flush & !mismatch) | xfer).
- Accept (frag_valid & frag_ready):
  - The fragment is written to lane 0 if xfer, else to lane count.
  - count becomes 1 or count+1 respectively; buf_uuid loads frag_uuid when writing lane 0.
  - Accepted frag_last sets pend_flush.
- Simultaneous xfer and accept: the old buffer goes to the output and the new fragment starts the new buffer; no bubble.
- out_valid:
  - Set on xfer.
  - Cleared on om_req_ready & !xfer.
  - The payload is held stable while valid & !ready.
- Timer:
  - Cleared on accept or xfer, and whenever count==0.
  - Otherwise increments, saturating at FLUSH_TIMEOUT.
- Latency: a fragment filling the buffer at edge N gives om_req_valid high after edge N+1 (two cycles), given no backpressure.
- Throughput: one fragment/cycle sustained; one request per NUM_LANES cycles.
- Lane order equals arrival order; requests leave in order.
- Full buffer with out_valid & !om_req_ready: frag_ready=0 until om_req_ready rises.
- frag_last on a fragment that fills the buffer: a single request is emitted, with no extra empty request.
- A request never has mask=0.

Test Plan:
- NUM_LANES=4, four fragments uuid=5, x=0..3, om_req_ready=1 -> one request, mask=4'b1111, pos_x={3,2,1,0}, om_req_valid two cycles after the fourth accept.
- Two fragments uuid=5, then a fragment uuid=6 -> request mask=4'b0011 uuid=5 emitted; uuid=6 fragment accepted in the same cycle into lane 0 of the next buffer.
- One fragment, then no input, FLUSH_TIMEOUT=16 -> request mask=4'b0001 emitted after 16 idle cycles; with FLUSH_TIMEOUT=0 no request, busy stays 1.
- Three fragments with frag_last on the third -> mask=4'b0111 emitted; the next fragment starts a fresh buffer.
- om_req_ready=0 for 20 cycles while streaming 12 fragments -> frag_ready drops after 8 accepted; payload stable; all 3 requests delivered in order after ready rises.
- reset pulsed low with count=3 and out_valid=1 -> om_req_valid=0 and busy=0 immediately; no stale request after release.

Source files
------------

// File: rtl/om_frag_packer_if.sv
// Fragment-in / OM-request-out handshake bundle for om_frag_packer.
// master drives fragments and sinks requests; slave is the packer.
interface om_frag_packer_if #(
    parameter int NUM_LANES  = 4,
    parameter int DIM_BITS   = 11,
    parameter int DEPTH_BITS = 24,
    parameter int COLOR_BITS = 32,
    parameter int UUID_WIDTH = 44
);
    logic                                  frag_valid;
    logic [UUID_WIDTH-1:0]                 frag_uuid;
    logic [DIM_BITS-1:0]                   frag_pos_x;
    logic [DIM_BITS-1:0]                   frag_pos_y;
    logic [COLOR_BITS-1:0]                 frag_color;
    logic [DEPTH_BITS-1:0]                 frag_depth;
    logic                                  frag_face;
    logic                                  frag_last;
    logic                                  frag_ready;

    logic                                  om_req_valid;
    logic [UUID_WIDTH-1:0]                 om_req_uuid;
    logic [NUM_LANES-1:0]                  om_req_mask;
    logic [NUM_LANES-1:0][DIM_BITS-1:0]    om_req_pos_x;
    logic [NUM_LANES-1:0][DIM_BITS-1:0]    om_req_pos_y;
    logic [NUM_LANES-1:0][COLOR_BITS-1:0]  om_req_color;
    logic [NUM_LANES-1:0][DEPTH_BITS-1:0]  om_req_depth;
    logic [NUM_LANES-1:0]                  om_req_face;
    logic                                  om_req_ready;

    modport master (
        output frag_valid, frag_uuid, frag_pos_x, frag_pos_y, frag_color,
               frag_depth, frag_face, frag_last,
        input  frag_ready,
        input  om_req_valid, om_req_uuid, om_req_mask, om_req_pos_x,
               om_req_pos_y, om_req_color, om_req_depth, om_req_face,
        output om_req_ready
    );

    modport slave (
        input  frag_valid, frag_uuid, frag_pos_x, frag_pos_y, frag_color,
               frag_depth, frag_face, frag_last,
        output frag_ready,
        output om_req_valid, om_req_uuid, om_req_mask, om_req_pos_x,
               om_req_pos_y, om_req_color, om_req_depth, om_req_face,
        input  om_req_ready
    );
endinterface

// File: rtl/om_frag_packer.sv
// Packs single shaded fragments into NUM_LANES-wide OM requests, flushing
// partial buffers on full, uuid change, last-fragment or idle timeout.
module om_frag_packer_lane #(
    parameter int DIM_BITS   = 11,
    parameter int DEPTH_BITS = 24,
    parameter int COLOR_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  ld,
    input  logic                  keep,
    input  logic [DIM_BITS-1:0]   in_x,
    input  logic [DIM_BITS-1:0]   in_y,
    input  logic [COLOR_BITS-1:0] in_color,
    input  logic [DEPTH_BITS-1:0] in_depth,
    input  logic                  in_face,
    output logic [DIM_BITS-1:0]   out_x,
    output logic [DIM_BITS-1:0]   out_y,
    output logic [COLOR_BITS-1:0] out_color,
    output logic [DEPTH_BITS-1:0] out_depth,
    output logic                  out_face
);
    typedef struct packed {
        logic [DIM_BITS-1:0]   x;
        logic [DIM_BITS-1:0]   y;
        logic [COLOR_BITS-1:0] color;
        logic [DEPTH_BITS-1:0] depth;
        logic                  face;
    } lane_t;

    lane_t buf_q, out_q;

    // On a combined load+write the output takes the old buffer value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            out_q <= '0;
        end else begin
            if (wr) buf_q <= '{in_x, in_y, in_color, in_depth, in_face};
            if (ld) out_q <= keep ? buf_q : '0;
        end
    end

    assign out_x     = out_q.x;
    assign out_y     = out_q.y;
    assign out_color = out_q.color;
    assign out_depth = out_q.depth;
    assign out_face  = out_q.face;
endmodule

module om_frag_packer #(
    parameter int NUM_LANES     = 4,
    parameter int DIM_BITS      = 11,
    parameter int DEPTH_BITS    = 24,
    parameter int COLOR_BITS    = 32,
    parameter int UUID_WIDTH    = 44,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    om_frag_packer_if.slave  bus,
    output logic             busy
);
    localparam int CW = $clog2(NUM_LANES + 1);
    localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    logic [CW-1:0]         count;
    logic [UUID_WIDTH-1:0] buf_uuid;
    logic                  pend_flush;
    logic [TW-1:0]         timer;
    logic                  out_valid;
    logic [UUID_WIDTH-1:0] out_uuid;
    logic [NUM_LANES-1:0]  out_mask;

    logic                  mismatch, tmo_hit, emit, xfer, accept;
    logic [CW-1:0]         wr_lane;
    logic [NUM_LANES-1:0]  fill;

    logic [NUM_LANES-1:0][DIM_BITS-1:0]   lane_x, lane_y;
    logic [NUM_LANES-1:0][COLOR_BITS-1:0] lane_color;
    logic [NUM_LANES-1:0][DEPTH_BITS-1:0] lane_depth;
    logic [NUM_LANES-1:0]                 lane_face;

    assign mismatch = bus.frag_valid && (count != '0) && (bus.frag_uuid != buf_uuid);
    assign tmo_hit  = (FLUSH_TIMEOUT != 0) && (timer == TW'(FLUSH_TIMEOUT));
    assign emit     = (count != '0) &&
                      ((count == CW'(NUM_LANES)) || pend_flush || mismatch || tmo_hit);
    assign xfer     = emit && (!out_valid || bus.om_req_ready);

    // A transfer frees the buffer in the same cycle, so a fragment can start
    // the next buffer without a bubble.
    assign bus.frag_ready = reset &&
        (((count < CW'(NUM_LANES)) && !pend_flush && !mismatch) || xfer);
    assign accept  = bus.frag_valid && bus.frag_ready;
    assign wr_lane = xfer ? '0 : count;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign fill[i] = CW'(i) < count;

        om_frag_packer_lane #(
            .DIM_BITS  (DIM_BITS),
            .DEPTH_BITS(DEPTH_BITS),
            .COLOR_BITS(COLOR_BITS)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr       (accept && (wr_lane == CW'(i))),
            .ld       (xfer),
            .keep     (fill[i]),
            .in_x     (bus.frag_pos_x),
            .in_y     (bus.frag_pos_y),
            .in_color (bus.frag_color),
            .in_depth (bus.frag_depth),
            .in_face  (bus.frag_face),
            .out_x    (lane_x[i]),
            .out_y    (lane_y[i]),
            .out_color(lane_color[i]),
            .out_depth(lane_depth[i]),
            .out_face (lane_face[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            buf_uuid   <= '0;
            pend_flush <= 1'b0;
            timer      <= '0;
            out_valid  <= 1'b0;
            out_uuid   <= '0;
            out_mask   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_uuid  <= buf_uuid;
                out_mask  <= fill;
            end else if (bus.om_req_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                count      <= xfer ? CW'(1) : count + CW'(1);
                pend_flush <= bus.frag_last;
                if (xfer || count == '0) buf_uuid <= bus.frag_uuid;
            end else if (xfer) begin
                count      <= '0;
                pend_flush <= 1'b0;
            end

            // Saturates at the limit so a blocked timeout flush stays armed.
            if (accept || xfer || count == '0)
                timer <= '0;
            else if (timer != TW'(FLUSH_TIMEOUT))
                timer <= timer + TW'(1);
        end
    end

    assign bus.om_req_valid = out_valid;
    assign bus.om_req_uuid  = out_uuid;
    assign bus.om_req_mask  = out_mask;
    assign bus.om_req_pos_x = lane_x;
    assign bus.om_req_pos_y = lane_y;
    assign bus.om_req_color = lane_color;
    assign bus.om_req_depth = lane_depth;
    assign bus.om_req_face  = lane_face;
    assign busy             = (count != '0) || out_valid;
endmodule

// File: tb/tb_om_frag_packer.sv
// Bench for om_frag_packer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_om_frag_packer;
    localparam int N = 4, DW = 8, DB = 16, CB = 32, UW = 8, TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy0;
    always #5 clk = ~clk;

    om_frag_packer_if #(.NUM_LANES(N), .DIM_BITS(DW), .DEPTH_BITS(DB),
                        .COLOR_BITS(CB), .UUID_WIDTH(UW)) bus ();
    om_frag_packer_if #(.NUM_LANES(N), .DIM_BITS(DW), .DEPTH_BITS(DB),
                        .COLOR_BITS(CB), .UUID_WIDTH(UW)) bus0 ();

    om_frag_packer #(.NUM_LANES(N), .DIM_BITS(DW), .DEPTH_BITS(DB), .COLOR_BITS(CB),
                     .UUID_WIDTH(UW), .FLUSH_TIMEOUT(TO))
        dut (.clk(clk), .reset(rst_n), .bus(bus.slave), .busy(busy));

    om_frag_packer #(.NUM_LANES(N), .DIM_BITS(DW), .DEPTH_BITS(DB), .COLOR_BITS(CB),
                     .UUID_WIDTH(UW), .FLUSH_TIMEOUT(0))
        dut0 (.clk(clk), .reset(rst_n), .bus(bus0.slave), .busy(busy0));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [UW-1:0] uuid;
        logic [DW-1:0] x, y;
        logic [CB-1:0] color;
        logic [DB-1:0] depth;
        logic          face, last;
    } frag_t;

    frag_t q[$];
    bit    m_pend, m_ov;
    int    idle;
    logic [UW-1:0]           e_uuid;
    logic [N-1:0]            e_mask, e_face;
    logic [N-1:0][DW-1:0]    e_x, e_y;
    logic [N-1:0][CB-1:0]    e_c;
    logic [N-1:0][DB-1:0]    e_d;

    always @(negedge clk) begin : compare
        frag_t f;
        bit mm, tmo, emit, xf, er, acc;
        int cnt;
        f = '{bus.frag_uuid, bus.frag_pos_x, bus.frag_pos_y, bus.frag_color,
              bus.frag_depth, bus.frag_face, bus.frag_last};
        cnt = q.size();
        er = 0; xf = 0; acc = 0;
        if (!rst_n) begin
            q.delete(); m_pend = 0; m_ov = 0; idle = 0;
            e_uuid = '0; e_mask = '0; e_face = '0; e_x = '0; e_y = '0; e_c = '0; e_d = '0;
            cnt = 0;
        end else begin
            mm   = bus.frag_valid && cnt > 0 && f.uuid != q[0].uuid;
            tmo  = TO != 0 && idle == TO;
            emit = cnt > 0 && (cnt == N || m_pend || mm || tmo);
            xf   = emit && (!m_ov || bus.om_req_ready);
            er   = (cnt < N && !m_pend && !mm) || xf;
            acc  = bus.frag_valid && er;
        end
        chk("frag_ready", 256'(bus.frag_ready), 256'(er));
        chk("req_valid",  256'(bus.om_req_valid), 256'(m_ov));
        chk("busy",       256'(busy), 256'(cnt > 0 || m_ov));
        chk("req_uuid",   256'(bus.om_req_uuid), 256'(e_uuid));
        chk("req_mask",   256'(bus.om_req_mask), 256'(e_mask));
        chk("req_pos_x",  256'(bus.om_req_pos_x), 256'(e_x));
        chk("req_pos_y",  256'(bus.om_req_pos_y), 256'(e_y));
        chk("req_color",  256'(bus.om_req_color), 256'(e_c));
        chk("req_depth",  256'(bus.om_req_depth), 256'(e_d));
        chk("req_face",   256'(bus.om_req_face), 256'(e_face));
        if (rst_n) begin
            if (xf) begin
                e_uuid = q[0].uuid;
                e_mask = '0; e_face = '0; e_x = '0; e_y = '0; e_c = '0; e_d = '0;
                for (int i = 0; i < cnt; i++) begin
                    e_mask[i] = 1'b1;
                    e_x[i] = q[i].x; e_y[i] = q[i].y; e_c[i] = q[i].color;
                    e_d[i] = q[i].depth; e_face[i] = q[i].face;
                end
                m_ov = 1;
            end else if (bus.om_req_ready) begin
                m_ov = 0;
            end
            if (acc || xf || cnt == 0) idle = 0;
            else if (idle < TO) idle++;
            if (xf) begin q.delete(); m_pend = 0; end
            if (acc) begin q.push_back(f); m_pend = f.last; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [UW-1:0] u, input logic [DW-1:0] x, input bit last);
        bus.frag_valid = 1'b1;
        bus.frag_uuid  = u;
        bus.frag_pos_x = x;
        bus.frag_pos_y = x + 8'd1;
        bus.frag_color = $urandom;
        bus.frag_depth = DB'($urandom);
        bus.frag_face  = x[0];
        bus.frag_last  = last;
    endtask

    // Cycles until om_req_valid is seen; -1 if the bound expires.
    task automatic wait_req(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            @(negedge clk);
            if (bus.om_req_valid) begin k = i; break; end
        end
    endtask

    initial begin : stim
        int k, idx, reqs, seen, gap;
        bit a;
        logic [N-1:0][DW-1:0] snap;
        bus.frag_valid = 0; bus.frag_uuid = '0; bus.frag_pos_x = '0; bus.frag_pos_y = '0;
        bus.frag_color = '0; bus.frag_depth = '0; bus.frag_face = 0; bus.frag_last = 0;
        bus.om_req_ready = 1;
        bus0.frag_valid = 0; bus0.frag_uuid = 8'd3; bus0.frag_pos_x = 8'd4; bus0.frag_pos_y = '0;
        bus0.frag_color = '0; bus0.frag_depth = '0; bus0.frag_face = 0; bus0.frag_last = 0;
        bus0.om_req_ready = 1;
        #1;
        chk("rst_valid", 256'(bus.om_req_valid), 256'(0));
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_ready", 256'(bus.frag_ready), 256'(0));
        repeat (3) tick();
        rst_n = 1;
        tick();

        // full buffer of four
        for (int i = 0; i < 4; i++) begin
            drive(8'd5, DW'(i), 0);
            @(negedge clk); chk("t1_ready", 256'(bus.frag_ready), 256'(1));
            tick();
        end
        bus.frag_valid = 0;
        @(negedge clk); chk("t1_early", 256'(bus.om_req_valid), 256'(0));
        tick();
        @(negedge clk);
        chk("t1_valid", 256'(bus.om_req_valid), 256'(1));
        chk("t1_mask",  256'(bus.om_req_mask), 256'(4'b1111));
        chk("t1_uuid",  256'(bus.om_req_uuid), 256'(5));
        chk("t1_posx",  256'(bus.om_req_pos_x), 256'(32'h03020100));
        tick();

        // uuid change flushes two, new uuid lands in lane 0 same cycle
        drive(8'd5, 8'd10, 0); tick();
        drive(8'd5, 8'd11, 0); tick();
        drive(8'd6, 8'd12, 0);
        @(negedge clk); chk("t2_ready", 256'(bus.frag_ready), 256'(1));
        tick();
        bus.frag_valid = 0;
        @(negedge clk);
        chk("t2_valid", 256'(bus.om_req_valid), 256'(1));
        chk("t2_mask",  256'(bus.om_req_mask), 256'(4'b0011));
        chk("t2_uuid",  256'(bus.om_req_uuid), 256'(5));
        chk("t2_posx",  256'(bus.om_req_pos_x), 256'(32'h00000b0a));

        // idle timeout flushes the lone uuid=6 fragment
        wait_req(k);
        chk("t3_latency", 256'(k), 256'(17));
        chk("t3_mask", 256'(bus.om_req_mask), 256'(4'b0001));
        chk("t3_uuid", 256'(bus.om_req_uuid), 256'(6));
        chk("t3_posx", 256'(bus.om_req_pos_x), 256'(32'h0000000c));
        tick();

        // frag_last on third fragment
        drive(8'd7, 8'd20, 0); tick();
        drive(8'd7, 8'd21, 0); tick();
        drive(8'd7, 8'd22, 1); tick();
        bus.frag_valid = 0;
        @(negedge clk); chk("t4_early", 256'(bus.om_req_valid), 256'(0));
        tick();
        @(negedge clk);
        chk("t4_valid", 256'(bus.om_req_valid), 256'(1));
        chk("t4_mask",  256'(bus.om_req_mask), 256'(4'b0111));
        drive(8'd7, 8'd23, 0); tick();
        bus.frag_valid = 0;
        wait_req(k);
        chk("t4_fresh_lat",  256'(k), 256'(17));
        chk("t4_fresh_mask", 256'(bus.om_req_mask), 256'(4'b0001));
        chk("t4_fresh_posx", 256'(bus.om_req_pos_x), 256'(32'h00000017));
        tick();

        // backpressure while streaming 12 fragments
        bus.om_req_ready = 0;
        idx = 0; reqs = 0; snap = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 20) bus.om_req_ready = 1;
            if (idx < 12) drive(8'd9, DW'(30 + idx), 0);
            else bus.frag_valid = 0;
            @(negedge clk);
            a = bus.frag_valid && bus.frag_ready;
            if (bus.om_req_valid && bus.om_req_ready) reqs++;
            if (cyc == 10) snap = bus.om_req_pos_x;
            if (cyc == 19) begin
                chk("t5_accepted",  256'(idx), 256'(8));
                chk("t5_stall_rdy", 256'(bus.frag_ready), 256'(0));
                chk("t5_stable",    256'(bus.om_req_pos_x), 256'(snap));
                chk("t5_posx",      256'(bus.om_req_pos_x), 256'(32'h21201f1e));
            end
            tick();
            if (a) idx++;
        end
        chk("t5_all_acc", 256'(idx), 256'(12));
        chk("t5_reqs",    256'(reqs), 256'(3));

        // reset mid-operation: count=3, out_valid=1
        bus.om_req_ready = 0;
        for (int i = 0; i < 7; i++) begin
            drive(8'd11, DW'(40 + i), 0);
            @(negedge clk); chk("t6_ready", 256'(bus.frag_ready), 256'(1));
            tick();
        end
        bus.frag_valid = 0;
        rst_n = 0;
        #1;
        chk("t6_valid", 256'(bus.om_req_valid), 256'(0));
        chk("t6_busy",  256'(busy), 256'(0));
        chk("t6_mask",  256'(bus.om_req_mask), 256'(0));
        tick();
        rst_n = 1;
        bus.om_req_ready = 1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (bus.om_req_valid) seen++;
        end
        chk("t6_stale", 256'(seen), 256'(0));

        // randomized traffic
        gap = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) rst_n = 0;
            else rst_n = 1;
            if (gap > 0) begin
                gap--;
                bus.frag_valid = 0;
            end else if ($urandom_range(0, 99) < 2) begin
                gap = $urandom_range(10, 25);
                bus.frag_valid = 0;
            end else begin
                bus.frag_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) < 15) bus.frag_uuid = UW'($urandom_range(0, 2));
                bus.frag_pos_x = DW'($urandom);
                bus.frag_pos_y = DW'($urandom);
                bus.frag_color = $urandom;
                bus.frag_depth = DB'($urandom);
                bus.frag_face  = 1'($urandom);
                bus.frag_last  = ($urandom_range(0, 9) == 0);
            end
            bus.om_req_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1;
        bus.frag_valid = 0;
        bus.om_req_ready = 1;
        repeat (40) tick();

        // timeout disabled: a lone fragment is held indefinitely
        bus0.frag_valid = 1;
        @(negedge clk); chk("t7_ready", 256'(bus0.frag_ready), 256'(1));
        tick();
        bus0.frag_valid = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (bus0.om_req_valid) seen++;
        end
        chk("t7_no_req", 256'(seen), 256'(0));
        chk("t7_busy",   256'(busy0), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
